// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types, defaults and helpers for the multichannel PWM.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Counting style of the shared period counter
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Direction of the center-aligned up/down counter
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 8;

  // Channel-select width; a single channel still needs a 1-bit select port
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM channel: pending/active duty registers, compare
//               against the shared counter, enable gating, output register.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SEL_W  = 4,
  parameter int CH_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_out,
  input  logic             en_pwm,
  input  logic             boundary,
  input  logic             duty_we,
  input  logic [SEL_W-1:0] duty_wsel,
  input  logic [CNT_W-1:0] duty_wdata,
  input  logic [CNT_W-1:0] cnt,
  output logic             out
);

  localparam logic [SEL_W-1:0] C_IDX = SEL_W'(CH_IDX);

  logic             w_hit;
  logic             w_raw;
  logic             w_out_nxt;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] r_active;

  // Selects outside 0..NUM_CH-1 match no channel, so such writes vanish
  assign w_hit = duty_we && (duty_wsel == C_IDX);

  // Unsigned compare: duty 0 never fires, duty above the period always fires
  assign w_raw = (cnt < r_active);

  // Disabled output forces low; output enabled without PWM forces high
  always_comb begin
    w_out_nxt = 1'b0;
    if (en_out) begin
      w_out_nxt = en_pwm ? w_raw : 1'b1;
    end
  end

  // Pending duty captures every write addressed to this channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else if (w_hit) begin
      r_pending <= duty_wdata;
    end
  end

  // Active duty reloads only at a boundary; a coincident write goes straight through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= '0;
    end else if (boundary) begin
      r_active <= w_hit ? duty_wdata : r_pending;
    end
  end

  // Registered output, one clock behind the counter and enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= 1'b0;
    end else begin
      out <= w_out_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multichannel
// Description : Multichannel PWM with a shared prescaler and period counter,
//               boundary-shadowed period/mode/duty, edge or center alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              en_out,
  input  logic [NUM_CH-1:0]              en_pwm,
  input  logic                           duty_we,
  input  logic [sel_width(NUM_CH)-1:0]   duty_wsel,
  input  logic [CNT_W-1:0]               duty_wdata,
  input  logic [CNT_W-1:0]               period,
  input  logic [PRESC_W-1:0]             prescale,
  input  logic                           mode,
  output logic [NUM_CH-1:0]              out,
  output logic                           period_tick
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [PRESC_W-1:0] r_presc_cnt;
  logic               w_tick;

  logic [CNT_W-1:0]   r_cnt;
  pwm_dir_e           r_dir;
  logic [CNT_W-1:0]   r_period_sh;
  pwm_mode_e          r_mode_sh;

  logic [CNT_W-1:0]   w_cnt_nxt;
  pwm_dir_e           w_dir_nxt;
  logic               w_wrap;
  logic               w_boundary;

  // A reload value lowered below the running count still ends the prescale
  // cycle right away instead of waiting for the counter to roll over
  assign w_tick = (r_presc_cnt >= prescale);

  // Prescaler: counts 0..prescale and wraps on the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
    end
  end

  // Next counter value and whether this step closes the period
  always_comb begin
    w_wrap    = 1'b0;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (r_mode_sh == PWM_EDGE) begin
      if (r_cnt >= r_period_sh) begin
        w_wrap = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else if (r_dir == DIR_UP) begin
      if (r_cnt >= r_period_sh) begin
        // Periods of 0 or 1 have no descending leg: the peak is also the end
        if (r_period_sh <= CNT_W'(1)) begin
          w_wrap = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          w_dir_nxt = DIR_DOWN;
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      if (r_cnt <= CNT_W'(1)) begin
        w_wrap = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
  end

  assign w_boundary = w_tick && w_wrap;

  // Period counter plus period/mode shadows, reloaded together at a boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_dir       <= DIR_UP;
      r_period_sh <= '0;
      r_mode_sh   <= PWM_EDGE;
    end else if (w_boundary) begin
      r_cnt       <= '0;
      r_dir       <= DIR_UP;
      r_period_sh <= period;
      r_mode_sh   <= pwm_mode_e'(mode);
    end else if (w_tick) begin
      r_cnt       <= w_cnt_nxt;
      r_dir       <= w_dir_nxt;
    end
  end

  // Boundary pulse, visible the clock after the boundary edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= w_boundary;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwm_channel #(
      .CNT_W  (CNT_W),
      .SEL_W  (SEL_W),
      .CH_IDX (gi)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_out     (en_out[gi]),
      .en_pwm     (en_pwm[gi]),
      .boundary   (w_boundary),
      .duty_we    (duty_we),
      .duty_wsel  (duty_wsel),
      .duty_wdata (duty_wdata),
      .cnt        (r_cnt),
      .out        (out[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multichannel
// Description : Self-checking bench for pwm_multichannel: per-period high
//               time and period length, shadowing, write-through and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multichannel;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic        duty_we;
  logic [3:0]  duty_wsel;
  logic [7:0]  duty_wdata;
  logic [7:0]  period;
  logic [7:0]  prescale;
  logic        mode;
  logic [15:0] out;
  logic        period_tick;

  pwm_multichannel #(
    .NUM_CH  (16),
    .CNT_W   (8),
    .PRESC_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_out      (en_out),
    .en_pwm      (en_pwm),
    .duty_we     (duty_we),
    .duty_wsel   (duty_wsel),
    .duty_wdata  (duty_wdata),
    .period      (period),
    .prescale    (prescale),
    .mode        (mode),
    .out         (out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int presc;
    int per;
    int md;
    int duty;
    bit eo;
    bit ep;
    int exp_len;
    int exp_hi;
  } vec_t;

  typedef struct {
    int len;
    int hi;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_duty(input int ch, input int d);
    duty_wsel  = 4'(ch);
    duty_wdata = 8'(d);
    duty_we    = 1'b1;
    @(negedge clk);
    duty_we    = 1'b0;
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (period_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: no period_tick within 400 clks");
    end
  endtask

  // Samples from just after one period_tick through the next one; optionally
  // drives a duty write and/or a period change after sample act_at
  task automatic count_window(input int ch, input int act_at, input int act_wsel,
                              input int act_duty, input int act_per,
                              output int len, output int hi, output logic [31:0] pat);
    len = 0;
    hi  = 0;
    pat = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (len < 32) pat[len] = out[ch];
      len++;
      hi += int'(out[ch]);
      if (period_tick) break;
      if (len == act_at) begin
        if (act_duty >= 0) begin
          duty_wsel  = 4'(act_wsel);
          duty_wdata = 8'(act_duty);
          duty_we    = 1'b1;
        end
        if (act_per >= 0) period = 8'(act_per);
      end else begin
        duty_we = 1'b0;
      end
    end
    duty_we = 1'b0;
  endtask

  task automatic pop_check(input string name, input int len, input int hi);
    exp_t e;
    e = sb.pop_front();
    check({name, " len"}, len, e.len);
    check({name, " hi"}, hi, e.hi);
  endtask

  task automatic setup(input int ch, input int presc, input int per, input int md,
                       input bit eo, input bit ep);
    prescale   = 8'(presc);
    period     = 8'(per);
    mode       = md[0];
    en_out     = '0;
    en_pwm     = '0;
    en_out[ch] = eo;
    en_pwm[ch] = ep;
    do_reset();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          len, hi;
    logic [31:0] pat;
    setup(v.ch, v.presc, v.per, v.md, v.eo, v.ep);
    sb.push_back('{v.exp_len, v.exp_hi});
    write_duty(v.ch, v.duty);
    repeat (3) wait_tick();
    count_window(v.ch, -1, 0, -1, -1, len, hi, pat);
    pop_check($sformatf("vec%0d", idx), len, hi);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          len, hi;
    logic [31:0] pat;

    //         ch presc per md duty eo ep len  hi
    vecs[0]  = '{0,  0,   9,  0, 3,   1, 1, 10,  3};
    vecs[1]  = '{0,  0,   9,  0, 0,   1, 1, 10,  0};
    vecs[2]  = '{2,  0,   9,  0, 10,  1, 1, 10,  10};
    vecs[3]  = '{3,  0,   9,  0, 4,   1, 0, 10,  10};
    vecs[4]  = '{4,  0,   9,  0, 5,   0, 1, 10,  0};
    vecs[5]  = '{5,  0,   4,  1, 2,   1, 1, 8,   3};
    vecs[6]  = '{6,  3,   1,  0, 1,   1, 1, 8,   4};
    vecs[7]  = '{7,  1,   4,  0, 2,   1, 1, 10,  4};
    vecs[8]  = '{8,  0,   4,  1, 5,   1, 1, 8,   8};
    vecs[9]  = '{9,  0,   0,  1, 1,   1, 1, 1,   1};
    vecs[10] = '{15, 0,   6,  1, 4,   1, 1, 12,  7};
    vecs[11] = '{11, 0,   255,0, 128, 1, 1, 256, 128};
    vecs[12] = '{12, 0,   3,  1, 1,   1, 1, 6,   1};

    rst        = 1'b1;
    en_out     = '0;
    en_pwm     = '0;
    duty_we    = 1'b0;
    duty_wsel  = '0;
    duty_wdata = '0;
    period     = '0;
    prescale   = '0;
    mode       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset out", int'(out), 0);
    check("reset tick", int'(period_tick), 0);
    period = 8'd9;
    @(negedge clk);
    check("reset tick held", int'(period_tick), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post reset out", int'(out), 0);

    // Table-driven per-period measurements
    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Edge waveform: ch0 high for the first 3 of 10 clks after the boundary
    setup(0, 0, 9, 0, 1'b1, 1'b1);
    write_duty(0, 3);
    repeat (3) wait_tick();
    count_window(0, -1, 0, -1, -1, len, hi, pat);
    check("edge len", len, 10);
    check("edge pattern", int'(pat[9:0]), 'b0000000111);

    // Center waveform: cnt 0,1,2,3,4,3,2,1 -> high at 0,1 and the trailing 1
    setup(0, 0, 4, 1, 1'b1, 1'b1);
    write_duty(0, 2);
    repeat (3) wait_tick();
    count_window(0, -1, 0, -1, -1, len, hi, pat);
    check("center len", len, 8);
    check("center pattern", int'(pat[7:0]), 'b10000011);

    // Shadowing: mid-period duty and period changes wait for the boundary
    setup(1, 0, 9, 0, 1'b1, 1'b1);
    write_duty(1, 2);
    repeat (3) wait_tick();
    sb.push_back('{10, 2});
    count_window(1, 3, 1, 7, -1, len, hi, pat);
    pop_check("shadow duty old", len, hi);
    sb.push_back('{10, 7});
    count_window(1, 3, 0, -1, 4, len, hi, pat);
    pop_check("shadow duty new", len, hi);
    sb.push_back('{5, 5});
    count_window(1, -1, 0, -1, -1, len, hi, pat);
    pop_check("shadow period new", len, hi);

    // Write-through: duty written on the boundary clk applies to that period
    setup(0, 3, 1, 0, 1'b1, 1'b1);
    repeat (3) wait_tick();
    sb.push_back('{8, 0});
    count_window(0, 7, 0, 1, -1, len, hi, pat);
    pop_check("wt before", len, hi);
    sb.push_back('{8, 4});
    count_window(0, -1, 0, -1, -1, len, hi, pat);
    pop_check("wt applied", len, hi);

    // Reset mid-period with the output high
    setup(0, 0, 9, 0, 1'b1, 1'b1);
    write_duty(0, 10);
    repeat (3) wait_tick();
    repeat (4) @(negedge clk);
    check("pre-reset out", int'(out[0]), 1);
    rst = 1'b1;
    #1;
    check("async reset out", int'(out), 0);
    check("async reset tick", int'(period_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick();
    sb.push_back('{10, 0});
    count_window(0, -1, 0, -1, -1, len, hi, pat);
    pop_check("after reset", len, hi);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
